// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the data-cache controller
//   dcache_state_t : controller FSM state encoding
package rv32i_types;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        HIT_CHECK   = 3'd1,
        WRITEBACK   = 3'd2,
        ALLOCATE    = 3'd3,
        REFILL_WAIT = 3'd4
    } dcache_state_t;

endpackage

// File: rtl/dcache_perf_cnt.sv
// rtl/dcache_perf_cnt.sv - saturating event counter with synchronous clear
//   clk, rst : clock, asynchronous active-high reset
//   i_inc    : count one event this cycle
//   i_clr    : zero the counter on the next edge (wins over i_inc)
//   o_cnt    : current count, sticks at all-ones
module dcache_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dcache_control.sv
// rtl/dcache_control.sv - data-cache control FSM with performance counters
//   clk, rst                      : clock, asynchronous active-high reset
//   mem_read, mem_write, mem_resp : CPU request / one-cycle completion
//   pmem_read, pmem_write, pmem_resp : line traffic to backing memory
//   is_hit, is_dirty              : datapath status (dirty bit of replace way)
//   is_allocate .. dirty_in       : datapath load / select controls
//   hit_cnt, miss_cnt, wb_cnt     : saturating performance counters
//   perf_clr                      : synchronous counter clear
module dcache_control
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             is_hit,
    input  logic             is_dirty,
    output logic             is_allocate,
    output logic             use_replace,
    output logic             load_data,
    output logic             load_tag,
    output logic             load_dirty,
    output logic             load_valid,
    output logic             load_plru,
    output logic             valid_in,
    output logic             dirty_in,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wb_cnt,
    input  logic             perf_clr
);

    dcache_state_t r_state;
    dcache_state_t w_next_state;
    logic          r_retry;     // current HIT_CHECK is the post-refill retry
    logic          w_req;
    logic          w_hit_inc;
    logic          w_miss_inc;
    logic          w_wb_inc;

    // A simultaneous read+write is served as a write: only mem_write
    // steers the write-hit controls below.
    assign w_req = mem_read | mem_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retry <= 1'b0;
        end else if ((r_state == ALLOCATE) && pmem_resp) begin
            r_retry <= 1'b1;
        end else if (r_state == HIT_CHECK) begin
            r_retry <= 1'b0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        is_allocate  = 1'b0;
        use_replace  = 1'b0;
        load_data    = 1'b0;
        load_tag     = 1'b0;
        load_dirty   = 1'b0;
        load_valid   = 1'b0;
        load_plru    = 1'b0;
        valid_in     = 1'b0;
        dirty_in     = 1'b0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_wb_inc     = 1'b0;

        case (r_state)
            IDLE: begin
                // One cycle here lets the tag/data SRAM read complete.
                if (w_req) begin
                    w_next_state = HIT_CHECK;
                end
            end
            HIT_CHECK: begin
                if (!w_req) begin
                    // Request dropped early: abandon it silently.
                    w_next_state = IDLE;
                end else if (is_hit) begin
                    mem_resp     = 1'b1;
                    load_plru    = 1'b1;
                    w_hit_inc    = ~r_retry;
                    w_next_state = IDLE;
                    if (mem_write) begin
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b1;
                    end
                end else begin
                    use_replace  = 1'b1;
                    w_miss_inc   = 1'b1;
                    w_next_state = is_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write  = 1'b1;
                use_replace = 1'b1;
                if (pmem_resp) begin
                    w_wb_inc     = 1'b1;
                    w_next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read   = 1'b1;
                is_allocate = 1'b1;
                use_replace = 1'b1;
                if (pmem_resp) begin
                    // Fill the replace way as a clean, valid line.
                    load_data    = 1'b1;
                    load_tag     = 1'b1;
                    load_valid   = 1'b1;
                    load_dirty   = 1'b1;
                    valid_in     = 1'b1;
                    dirty_in     = 1'b0;
                    w_next_state = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                // Give the SRAM a cycle to re-read the freshly filled line.
                w_next_state = HIT_CHECK;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    dcache_perf_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_hit_inc),
        .i_clr (perf_clr),
        .o_cnt (hit_cnt)
    );

    dcache_perf_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_miss_inc),
        .i_clr (perf_clr),
        .o_cnt (miss_cnt)
    );

    dcache_perf_cnt #(.CNT_W(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_wb_inc),
        .i_clr (perf_clr),
        .o_cnt (wb_cnt)
    );

endmodule

// File: tb/tb_dcache_control.sv
// tb/tb_dcache_control.sv - directed self-checking bench for dcache_control
module tb_dcache_control;

    logic clk = 1'b0;
    logic rst;
    logic mem_read, mem_write, pmem_resp, is_hit, is_dirty, perf_clr;

    wire [11:0] outs;
    wire [11:0] outs4;
    wire [31:0] hit_cnt, miss_cnt, wb_cnt;
    wire [3:0]  hit_cnt4, miss_cnt4, wb_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    // outs bit order: mem_resp pmem_read pmem_write is_allocate use_replace
    // load_data load_tag load_dirty load_valid load_plru valid_in dirty_in
    localparam logic [11:0] O_NONE  = 12'h000;
    localparam logic [11:0] O_RHIT  = 12'h804;
    localparam logic [11:0] O_WHIT  = 12'h855;
    localparam logic [11:0] O_MISS  = 12'h080;
    localparam logic [11:0] O_WB    = 12'h280;
    localparam logic [11:0] O_ALLOC = 12'h580;
    localparam logic [11:0] O_FILL  = 12'h5FA;

    dcache_control #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(outs[11]), .pmem_read(outs[10]), .pmem_write(outs[9]),
        .pmem_resp(pmem_resp), .is_hit(is_hit), .is_dirty(is_dirty),
        .is_allocate(outs[8]), .use_replace(outs[7]), .load_data(outs[6]),
        .load_tag(outs[5]), .load_dirty(outs[4]), .load_valid(outs[3]),
        .load_plru(outs[2]), .valid_in(outs[1]), .dirty_in(outs[0]),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt),
        .perf_clr(perf_clr)
    );

    dcache_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(outs4[11]), .pmem_read(outs4[10]), .pmem_write(outs4[9]),
        .pmem_resp(pmem_resp), .is_hit(is_hit), .is_dirty(is_dirty),
        .is_allocate(outs4[8]), .use_replace(outs4[7]), .load_data(outs4[6]),
        .load_tag(outs4[5]), .load_dirty(outs4[4]), .load_valid(outs4[3]),
        .load_plru(outs4[2]), .valid_in(outs4[1]), .dirty_in(outs4[0]),
        .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4), .wb_cnt(wb_cnt4),
        .perf_clr(perf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_read = 0; mem_write = 0; pmem_resp = 0;
        is_hit = 0; is_dirty = 0; perf_clr = 0;
        #1;
        chk("reset_outs", 64'(outs), 64'(O_NONE));
        chk("reset_cnts", {hit_cnt, miss_cnt}, 64'd0);
        chk("reset_wb", 64'(wb_cnt), 64'd0);
        tick(); tick();
        rst = 1'b0;

        // read hit
        mem_read = 1; is_hit = 1; #1;
        chk("rhit_idle", 64'(outs), 64'(O_NONE));
        tick();
        chk("rhit_resp", 64'(outs), 64'(O_RHIT));
        tick(); mem_read = 0; #1;
        chk("rhit_done", 64'(outs), 64'(O_NONE));
        chk("rhit_cnt", 64'(hit_cnt), 64'd1);

        // write hit
        mem_write = 1; tick();
        chk("whit_resp", 64'(outs), 64'(O_WHIT));
        tick(); mem_write = 0; #1;
        chk("whit_cnt", 64'(hit_cnt), 64'd2);

        // read and write together behave as a write
        mem_read = 1; mem_write = 1; tick();
        chk("rwhit_resp", 64'(outs), 64'(O_WHIT));
        tick(); mem_read = 0; mem_write = 0; #1;
        chk("rwhit_cnt", 64'(hit_cnt), 64'd3);

        // stray pmem_resp in IDLE is ignored
        pmem_resp = 1; #1;
        chk("stray_now", 64'(outs), 64'(O_NONE));
        tick(); pmem_resp = 0; #1;
        chk("stray_next", 64'(outs), 64'(O_NONE));

        // clean miss, pmem_resp in the 5th ALLOCATE cycle
        mem_read = 1; is_hit = 0; is_dirty = 0; tick();
        chk("cmiss_check", 64'(outs), 64'(O_MISS));
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cmiss_alloc%0d", i), 64'(outs), 64'(O_ALLOC));
            tick();
        end
        pmem_resp = 1; #1;
        chk("cmiss_fill", 64'(outs), 64'(O_FILL));
        tick(); pmem_resp = 0; is_hit = 1; #1;
        chk("cmiss_refill_wait", 64'(outs), 64'(O_NONE));
        chk("cmiss_misscnt", 64'(miss_cnt), 64'd1);
        tick();
        chk("cmiss_retry_resp", 64'(outs), 64'(O_RHIT));
        tick(); mem_read = 0; #1;
        chk("cmiss_hitcnt", 64'(hit_cnt), 64'd3);
        chk("cmiss_idle", 64'(outs), 64'(O_NONE));

        // dirty miss on a write
        mem_write = 1; is_hit = 0; is_dirty = 1; tick();
        chk("dmiss_check", 64'(outs), 64'(O_MISS));
        tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dmiss_wb%0d", i), 64'(outs), 64'(O_WB));
            tick();
        end
        pmem_resp = 1; #1;
        chk("dmiss_wb_last", 64'(outs), 64'(O_WB));
        tick(); pmem_resp = 0; #1;
        chk("dmiss_wbcnt", 64'(wb_cnt), 64'd1);
        chk("dmiss_misscnt", 64'(miss_cnt), 64'd2);
        chk("dmiss_alloc", 64'(outs), 64'(O_ALLOC));
        tick(); pmem_resp = 1; #1;
        chk("dmiss_fill", 64'(outs), 64'(O_FILL));
        tick(); pmem_resp = 0; is_hit = 1; is_dirty = 0; #1;
        chk("dmiss_refill_wait", 64'(outs), 64'(O_NONE));
        tick();
        chk("dmiss_retry_resp", 64'(outs), 64'(O_WHIT));
        tick(); mem_write = 0; #1;
        chk("dmiss_hitcnt", 64'(hit_cnt), 64'd3);

        // request dropped during HIT_CHECK
        mem_read = 1; is_hit = 0; tick();
        mem_read = 0; #1;
        chk("drop_check", 64'(outs), 64'(O_NONE));
        tick();
        chk("drop_idle", 64'(outs), 64'(O_NONE));
        chk("drop_misscnt", 64'(miss_cnt), 64'd2);

        // asynchronous reset in the middle of ALLOCATE
        mem_read = 1; is_hit = 0; is_dirty = 0; tick(); tick();
        chk("rstalloc_pre", 64'(outs), 64'(O_ALLOC));
        #2; rst = 1; #1;
        chk("rstalloc_outs", 64'(outs), 64'(O_NONE));
        chk("rstalloc_cnts", {hit_cnt, miss_cnt}, 64'd0);
        chk("rstalloc_wb", 64'(wb_cnt), 64'd0);
        mem_read = 0;
        tick();
        rst = 0; #1;
        chk("rstalloc_idle", 64'(outs), 64'(O_NONE));

        // 16 hits: 4-bit counter saturates, 32-bit counter does not
        is_hit = 1;
        for (int i = 0; i < 16; i++) begin
            mem_read = 1; tick();
            tick(); mem_read = 0; #1;
        end
        chk("sat_hit4", 64'(hit_cnt4), 64'd15);
        chk("sat_hit32", 64'(hit_cnt), 64'd16);

        // clear wins over a same-cycle hit
        mem_read = 1; tick();
        perf_clr = 1; #1;
        chk("clr_resp", 64'(outs), 64'(O_RHIT));
        tick(); perf_clr = 0; mem_read = 0; #1;
        chk("clr_hit4", 64'(hit_cnt4), 64'd0);
        chk("clr_hit32", 64'(hit_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_control.md
DCACHE_CONTROL -- requirements
Module: dcache_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the width of each performance counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports mem_read and mem_write, input, 1 bit each: CPU request, held until mem_resp.
REQ-005 SHALL have port mem_resp, output, 1 bit: one-cycle completion pulse to the CPU.
REQ-006 SHALL have ports pmem_read and pmem_write, output, 1 bit each: line requests to memory.
REQ-007 SHALL have port pmem_resp, input, 1 bit: memory completion pulse.
REQ-008 SHALL have ports is_hit and is_dirty, input, 1 bit each: datapath status (dirty bit of the replace way).
REQ-009 SHALL have ports is_allocate, use_replace, load_data, load_tag, load_dirty, load_valid, load_plru, valid_in, dirty_in, output, 1 bit each: datapath controls.
REQ-010 SHALL have ports hit_cnt, miss_cnt, wb_cnt, output, CNT_W bits each: performance counters.
REQ-011 SHALL have port perf_clr, input, 1 bit: synchronous counter clear.

Function
REQ-012 SHALL implement states IDLE, HIT_CHECK, WRITEBACK, ALLOCATE, REFILL_WAIT.
REQ-013 IDLE: all outputs 0; if mem_read or mem_write then go to HIT_CHECK on the next edge (1 cycle for the SRAM read).
REQ-014 HIT_CHECK, is_hit=1: mem_resp=1 and load_plru=1 in that cycle, then go to IDLE.
REQ-015 HIT_CHECK, is_hit=1 with mem_write=1: additionally load_data=1, load_dirty=1, dirty_in=1.
REQ-016 HIT_CHECK, is_hit=0: use_replace=1; go to WRITEBACK if is_dirty=1, else ALLOCATE.
REQ-017 WRITEBACK: pmem_write=1, use_replace=1, is_allocate=0; hold until pmem_resp=1, then go to ALLOCATE.
REQ-018 ALLOCATE: pmem_read=1, is_allocate=1, use_replace=1; hold until pmem_resp=1.
REQ-019 ALLOCATE, pmem_resp=1 cycle: load_data, load_tag, load_valid, load_dirty =1; valid_in=1; dirty_in=0; then go to REFILL_WAIT.
REQ-020 REFILL_WAIT: all outputs 0 for exactly 1 cycle, then go to HIT_CHECK; the retry SHALL hit and complete the request.
REQ-021 Hit latency SHALL be 2 cycles (request to mem_resp); a clean miss SHALL take pmem latency + 4 cycles.
REQ-022 mem_read and mem_write both high SHALL be treated as a write.
REQ-023 pmem_resp outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-024 Request deasserted in HIT_CHECK (protocol violation) SHALL return to IDLE with no outputs asserted.
REQ-025 pmem_read and pmem_write SHALL never be high together; mem_resp SHALL never assert outside HIT_CHECK.
REQ-026 hit_cnt SHALL increment on each mem_resp from a first-pass hit (not retry after refill); miss_cnt on each HIT_CHECK→WRITEBACK/ALLOCATE; wb_cnt on each WRITEBACK exit.
REQ-027 Counters SHALL saturate at all-ones, not wrap.
REQ-028 perf_clr SHALL zero all counters next edge and takes priority over a same-cycle increment.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, all control outputs 0, all counters 0, independent of clk.
REQ-030 Reset mid-WRITEBACK/ALLOCATE SHALL drop pmem_read/pmem_write asynchronously; no datapath load SHALL occur.

Structure
REQ-031 State enum dcache_state_t SHALL live in shared package rv32i_types.
REQ-032 Outputs SHALL be combinational from state and inputs; only the state register, a retry flag and the counters are sequential.
REQ-033 One sub-module, dcache_perf_cnt (saturating counter with inc/clr, width CNT_W), SHALL be instantiated three times.

Verification
REQ-034 Read hit: mem_read=1, is_hit=1 → mem_resp at cycle 2, load_plru=1, hit_cnt 0→1.
REQ-035 Write hit: mem_write=1, is_hit=1 → load_data=load_dirty=dirty_in=1 with mem_resp in one cycle.
REQ-036 Clean miss, pmem_resp after 5 cycles → pmem_read 5 cycles, refill loads, REFILL_WAIT, mem_resp at cycle 9, miss_cnt=1, hit_cnt=0.
REQ-037 Dirty miss → pmem_write until pmem_resp, then pmem_read, wb_cnt=1; pmem_read/pmem_write never overlap.
REQ-038 rst asserted during ALLOCATE → pmem_read low same cycle, state IDLE, counters 0.
REQ-039 CNT_W=4, 16 hits → hit_cnt=15 (saturated); perf_clr with a same-cycle hit → 0.
